// File: rtl/memory_arbiter_if.sv
// Requester ports and memory bus of the two-port memory arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface memory_arbiter_if;
  logic        P_Req, P_Write;
  logic [31:0] P_Address, P_Data_In, P_Data_Out;
  logic        P_Done, P_Error;
  logic        D_Req, D_Write;
  logic [31:0] D_Address, D_Data_In, D_Data_Out;
  logic        D_Done, D_Error;
  logic [31:0] MEM_Address, MEM_Data_In, MEM_Data_Out;
  logic [1:0]  MEM_r_w_z_z;
  logic        MEM_MFC, MEM_ERROR;
  logic [1:0]  Grant;

  modport slave (
    input  P_Req, P_Write, P_Address, P_Data_In,
    output P_Data_Out, P_Done, P_Error,
    input  D_Req, D_Write, D_Address, D_Data_In,
    output D_Data_Out, D_Done, D_Error,
    output MEM_Address, MEM_Data_In, MEM_r_w_z_z, Grant,
    input  MEM_Data_Out, MEM_MFC, MEM_ERROR
  );

  modport master (
    output P_Req, P_Write, P_Address, P_Data_In,
    input  P_Data_Out, P_Done, P_Error,
    output D_Req, D_Write, D_Address, D_Data_In,
    input  D_Data_Out, D_Done, D_Error,
    input  MEM_Address, MEM_Data_In, MEM_r_w_z_z, Grant,
    output MEM_Data_Out, MEM_MFC, MEM_ERROR
  );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter between processor and debug requesters for a shared
// memory bus, with MFC wait, error/timeout reporting and a turnaround cycle.
module memory_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             Clock,
  input  logic             Reset,
  memory_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

  localparam logic [1:0]  RW_IDLE  = 2'b10;
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic [31:0] addr_q, wdata_q, p_dout_q, d_dout_q;
  logic [1:0]  rw_q, grant_q;
  logic        last_q;   // 1: debug was granted most recently
  logic        owner_q;  // 1: debug owns the current access
  logic        write_q;
  logic [15:0] cnt_q;
  logic        p_done_q, p_err_q, d_done_q, d_err_q;

  logic pick_d_d, fin_d, fail_d;

  // Debug wins when it is alone, or on a tie when the processor went last.
  assign pick_d_d = bus.D_Req && (!bus.P_Req || !last_q);

  always_comb begin
    fin_d  = 1'b0;
    fail_d = 1'b0;
    if (bus.MEM_ERROR) begin
      fin_d  = 1'b1;
      fail_d = 1'b1;
    end else if (bus.MEM_MFC) begin
      fin_d  = 1'b1;
    end else if (cnt_q == CNT_LAST) begin
      fin_d  = 1'b1;
      fail_d = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rw_q     <= RW_IDLE;
      grant_q  <= 2'b00;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      write_q  <= 1'b0;
      cnt_q    <= '0;
      p_done_q <= 1'b0;
      p_err_q  <= 1'b0;
      d_done_q <= 1'b0;
      d_err_q  <= 1'b0;
      p_dout_q <= '0;
      d_dout_q <= '0;
    end else begin
      p_done_q <= 1'b0;
      p_err_q  <= 1'b0;
      d_done_q <= 1'b0;
      d_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.P_Req || bus.D_Req) begin
            owner_q <= pick_d_d;
            last_q  <= pick_d_d;
            addr_q  <= pick_d_d ? bus.D_Address : bus.P_Address;
            wdata_q <= pick_d_d ? bus.D_Data_In : bus.P_Data_In;
            write_q <= pick_d_d ? bus.D_Write   : bus.P_Write;
            rw_q    <= {1'b0, pick_d_d ? bus.D_Write : bus.P_Write};
            grant_q <= pick_d_d ? 2'b10 : 2'b01;
            cnt_q   <= '0;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (fin_d) begin
            if (owner_q) begin
              d_done_q <= 1'b1;
              d_err_q  <= fail_d;
            end else begin
              p_done_q <= 1'b1;
              p_err_q  <= fail_d;
            end
            if (!fail_d && !write_q) begin
              if (owner_q) d_dout_q <= bus.MEM_Data_Out;
              else         p_dout_q <= bus.MEM_Data_Out;
            end
            rw_q    <= RW_IDLE;
            grant_q <= 2'b00;
            state_q <= RELEASE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RELEASE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.MEM_Address = addr_q;
  assign bus.MEM_Data_In = wdata_q;
  assign bus.MEM_r_w_z_z = rw_q;
  assign bus.Grant       = grant_q;
  assign bus.P_Data_Out  = p_dout_q;
  assign bus.P_Done      = p_done_q;
  assign bus.P_Error     = p_err_q;
  assign bus.D_Data_Out  = d_dout_q;
  assign bus.D_Done      = d_done_q;
  assign bus.D_Error     = d_err_q;
endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized self-checking bench for memory_arbiter with a transaction-level
// reference model of arbitration, completion timing and read-data retention.
module tb_memory_arbiter;
  localparam int TO = 8;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_mis = 0;

  // reference model state
  int          m_last;          // 0 = processor granted last, 1 = debug
  logic [31:0] m_pdout, m_ddout;

  memory_arbiter_if bus ();

  memory_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".grant"}, bus.Grant, 32'd0);
    check({tag, ".rw"}, bus.MEM_r_w_z_z, 32'd2);
    check({tag, ".done"}, {bus.P_Done, bus.P_Error, bus.D_Done, bus.D_Error}, 32'd0);
    check({tag, ".pdout"}, bus.P_Data_Out, m_pdout);
    check({tag, ".ddout"}, bus.D_Data_Out, m_ddout);
  endtask

  task automatic set_port(input int port, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data);
    if (port == 0) begin
      bus.P_Req = 1'b1; bus.P_Write = wr; bus.P_Address = addr; bus.P_Data_In = data;
    end else begin
      bus.D_Req = 1'b1; bus.D_Write = wr; bus.D_Address = addr; bus.D_Data_In = data;
    end
  endtask

  task automatic scramble_port(input int port);
    if (port == 0) begin
      bus.P_Req = 1'b0; bus.P_Write = 1'($urandom);
      bus.P_Address = $urandom; bus.P_Data_In = $urandom;
    end else begin
      bus.D_Req = 1'b0; bus.D_Write = 1'($urandom);
      bus.D_Address = $urandom; bus.D_Data_In = $urandom;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.P_Req = 1'($urandom); bus.D_Req = 1'($urandom);
    bus.P_Write = 1'($urandom); bus.D_Write = 1'($urandom);
    bus.P_Address = $urandom; bus.D_Address = $urandom;
    bus.P_Data_In = $urandom; bus.D_Data_In = $urandom;
    bus.MEM_MFC = 1'($urandom); bus.MEM_ERROR = 1'($urandom);
    bus.MEM_Data_Out = $urandom;
    @(negedge clk);
    @(negedge clk);
    m_last = 1; m_pdout = '0; m_ddout = '0;
    check_quiet("reset");
    check("reset.addr", bus.MEM_Address, 32'd0);
    check("reset.wdata", bus.MEM_Data_In, 32'd0);
    rst = 1'b0;
    scramble_port(0);
    scramble_port(1);
  endtask

  // Call right after a negedge with the DUT idle and at least one Req high.
  // kind: 0 = MFC, 1 = ERROR, 2 = ERROR+MFC, 3 = no response; k = response edge.
  task automatic run_txn(input int kind, input int k, input logic [31:0] rdata,
                         output int who);
    int          w, fin;
    bit          err, ew;
    logic [31:0] ea, ed;
    if (bus.P_Req && bus.D_Req) w = (m_last == 0) ? 1 : 0;
    else                        w = bus.D_Req ? 1 : 0;
    ea = w ? bus.D_Address : bus.P_Address;
    ed = w ? bus.D_Data_In : bus.P_Data_In;
    ew = w ? bus.D_Write   : bus.P_Write;
    if (kind != 3 && k >= 1 && k <= TO) begin
      fin = k;
      err = (kind != 0);
    end else begin
      fin = TO;
      err = 1'b1;
    end
    @(negedge clk);
    for (int j = 1; j <= fin; j++) begin
      check("acc.grant", bus.Grant, w ? 32'd2 : 32'd1);
      check("acc.rw", bus.MEM_r_w_z_z, {31'd0, ew});
      check("acc.addr", bus.MEM_Address, ea);
      check("acc.wdata", bus.MEM_Data_In, ed);
      check("acc.done", {bus.P_Done, bus.D_Done}, 32'd0);
      bus.MEM_MFC      = (j == k) && (kind == 0 || kind == 2);
      bus.MEM_ERROR    = (j == k) && (kind == 1 || kind == 2);
      bus.MEM_Data_Out = (j == k) ? rdata : $urandom;
      @(negedge clk);
    end
    m_last = w;
    if (!err && !ew) begin
      if (w == 1) m_ddout = rdata;
      else        m_pdout = rdata;
    end
    check("end.pdone", {bus.P_Done, bus.P_Error}, (w == 0) ? {30'd0, 1'b1, err} : 32'd0);
    check("end.ddone", {bus.D_Done, bus.D_Error}, (w == 1) ? {30'd0, 1'b1, err} : 32'd0);
    check("end.grant", bus.Grant, 32'd0);
    check("end.rw", bus.MEM_r_w_z_z, 32'd2);
    check("end.pdout", bus.P_Data_Out, m_pdout);
    check("end.ddout", bus.D_Data_Out, m_ddout);
    bus.MEM_MFC = 1'($urandom); bus.MEM_ERROR = 1'($urandom); bus.MEM_Data_Out = $urandom;
    scramble_port(w);
    @(negedge clk);
    check_quiet("turn");
    bus.MEM_MFC = 1'($urandom); bus.MEM_ERROR = 1'($urandom);
    who = w;
  endtask

  initial begin
    int who, kind, k;
    rst = 1'b0;
    do_reset();

    // MFC/ERROR noise while idle must not complete anything
    for (int i = 0; i < 4; i++) begin
      bus.MEM_MFC = 1'($urandom); bus.MEM_ERROR = 1'($urandom);
      @(negedge clk);
      check_quiet("idle");
    end

    set_port(0, 1'b0, 32'h10, $urandom);
    run_txn(0, 3, 32'hDEADBEEF, who);
    check("pread.who", who, 32'd0);
    check("pread.data", bus.P_Data_Out, 32'hDEADBEEF);

    set_port(1, 1'b1, 32'h20, 32'h12345678);
    run_txn(0, 2, $urandom, who);
    check("dwrite.who", who, 32'd1);

    // continuous contention alternates P, D, P, D
    do_reset();
    set_port(0, 1'($urandom), $urandom, $urandom);
    set_port(1, 1'($urandom), $urandom, $urandom);
    for (int i = 0; i < 4; i++) begin
      run_txn(0, int'($urandom_range(1, 4)), $urandom, who);
      check("cont.order", who, i % 2);
      if (i < 3) set_port(who, 1'($urandom), $urandom, $urandom);
    end
    scramble_port(0);
    scramble_port(1);
    @(negedge clk);

    set_port(0, 1'b0, $urandom, $urandom);
    run_txn(3, 0, $urandom, who);

    set_port(0, 1'b0, $urandom, $urandom);
    run_txn(2, 2, $urandom, who);

    // reset in the middle of a debug read
    set_port(1, 1'b0, $urandom, $urandom);
    bus.MEM_MFC = 1'b0; bus.MEM_ERROR = 1'b0;
    @(negedge clk);
    check("rmid.grant", bus.Grant, 32'd2);
    @(negedge clk);
    rst = 1'b1;
    bus.D_Req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_last = 1; m_pdout = '0; m_ddout = '0;
    check_quiet("rmid.reset");
    bus.MEM_MFC = 1'b1;
    @(negedge clk);
    check_quiet("rmid.mfc");
    bus.MEM_MFC = 1'b0;
    set_port(0, 1'($urandom), $urandom, $urandom);
    set_port(1, 1'($urandom), $urandom, $urandom);
    run_txn(0, 1, $urandom, who);
    check("rmid.tie", who, 32'd0);

    // random traffic
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 29) == 0) do_reset();
      if (!bus.P_Req && $urandom_range(0, 1)) set_port(0, 1'($urandom), $urandom, $urandom);
      if (!bus.D_Req && $urandom_range(0, 1)) set_port(1, 1'($urandom), $urandom, $urandom);
      if (!bus.P_Req && !bus.D_Req) set_port(int'($urandom_range(0, 1)), 1'($urandom),
                                             $urandom, $urandom);
      kind = int'($urandom_range(0, 5));
      if (kind > 3) kind = 0;
      k = int'($urandom_range(1, 10));
      run_txn(kind, k, $urandom, who);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-port arbiter and access sequencer for the shared `MemoryInterface` in `MasterVerilog`. It sits between `Processor` and a second debug requester, for example a switch-driven memory viewer, and the memory bus. It grants the bus round-robin and drives the `MEM_r_w_z_z` / `MEM_Address` / `MEM_Data_In` protocol. It waits for `MEM_MFC`, reports `MEM_ERROR` and an MFC timeout back to the requester, and releases the bus to high impedance between accesses.

## Interface
- `TIMEOUT_CYCLES`, default 255: number of ACCESS cycles allowed for MFC before an error is reported; legal range 1..65535.
- `Clock`  in  1: single clock; every register updates on the rising edge.
- `Reset`  in  1: synchronous, active-high.
- `P_Req`, `P_Write`  in  1 each: processor request (level) and direction (1 = write).
- `P_Address`, `P_Data_In`  in  32 each: processor word address and write data.
- `P_Data_Out`  out  32: last read data returned to the processor.
- `P_Done`, `P_Error`  out  1 each: one-cycle completion pulse, and an error flag valid while `P_Done` is high.
- `D_Req`, `D_Write`, `D_Address`, `D_Data_In`, `D_Data_Out`, `D_Done`, `D_Error`: the same set for the debug port.
- `MEM_Address`, `MEM_Data_In`  out  32 each: to memory.
- `MEM_r_w_z_z`  out  2: 00 = read, 01 = write, 10 = high-Z/idle.
- `MEM_Data_Out`  in  32: read data from memory.
- `MEM_MFC`, `MEM_ERROR`  in  1 each: memory function complete, and address not assigned.
- `Grant`  out  2: one-hot owner (01 = processor, 10 = debug, 00 = none), for display.

## Operation
- **States:** IDLE, ACCESS, RELEASE.
- **IDLE:**
  - If no request is pending, stay in IDLE.
  - If one request is pending, grant it.
  - If both are pending, grant the port that was not granted last (`last` pointer).
  - On grant:
    - latch that port's Address/Data_In/Write into the bus registers;
    - set `Grant`;
    - update `last`;
    - clear the timeout counter;
    - go to ACCESS.
  - `MEM_MFC` and `MEM_ERROR` are ignored in IDLE and RELEASE.
- **ACCESS:** bus outputs hold the latched values; `MEM_r_w_z_z` = {0, Write}. At each edge:
  - if `MEM_ERROR` = 1: Done=1, Error=1, data unchanged, go to RELEASE. ERROR has priority over a simultaneous MFC.
  - else if `MEM_MFC` = 1: Done=1, Error=0; on a read, capture `MEM_Data_Out` into the granted port's Data_Out; go to RELEASE.
  - else if counter = `TIMEOUT_CYCLES`−1: Done=1, Error=1, go to RELEASE (timeout).
  - else increment the counter.
- **RELEASE:**
  - `MEM_r_w_z_z` = 10 and `Grant` = 00; Done/Error are high for this one cycle only.
  - Next edge goes to IDLE, which gives one bus-turnaround cycle.
- **Requester rules:**
  - A requester holds Req, Write, Address and Data_In stable until it sees its Done.
  - It must drop Req no later than the cycle after Done, or a new transaction is started.
  - Inputs of a non-granted port are never sampled.
- **Data_Out:** holds its value until the next successful read on the same port. A write, error or timeout leaves it unchanged.
- **Reset (any state, including mid-ACCESS):**
  - state goes to IDLE;
  - `MEM_r_w_z_z` = 10, `MEM_Address` = 0, `MEM_Data_In` = 0;
  - `Grant` = 00, all Done/Error = 0, both Data_Out = 0;
  - `last` = debug, so the processor wins the first tie;
  - counter = 0;
  - the aborted access produces no Done.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- **Grant (edge E0):** Req is sampled high in IDLE at E0. From E0, `Grant`, `MEM_Address`, `MEM_Data_In` and `MEM_r_w_z_z` are valid.
- **Completion (edge En, n ≥ 1):**
  - MFC is sampled at edge En.
  - Done is high from En to En+1; the bus is at 10 during that same cycle.
  - State is IDLE after En+1; the earliest next grant is at En+2.
  - Minimum access is 3 cycles from grant to next possible grant (MFC at E1).
- **Timeout:** with no MFC/ERROR, Done=1 and Error=1 are asserted at edge E_T, where T = `TIMEOUT_CYCLES`.
- **Fairness:** under continuous contention, grants strictly alternate P, D, P, D, …

## Test plan
- **Reset:**
  - Action: assert Reset for 2 cycles with random inputs.
  - Check: `MEM_r_w_z_z`=10, `Grant`=00, Done/Error=0, Data_Out=0.
  - Check: MFC pulses in IDLE produce no Done.
- **Processor read:**
  - Action: read `P_Address`=0x10; memory model returns 0xDEADBEEF with MFC at E3.
  - Check: `MEM_r_w_z_z`=00 and `Grant`=01 during E0..E3.
  - Check: `P_Done`=1, `P_Error`=0 for exactly one cycle after E3; `P_Data_Out`=0xDEADBEEF; `D_Data_Out` stays 0.
- **Debug write:**
  - Action: write `D_Address`=0x20, data 0x12345678.
  - Check: `MEM_r_w_z_z`=01, `MEM_Address`=0x20, `MEM_Data_In`=0x12345678, `Grant`=10.
  - Check: after MFC, `D_Done` pulses; `D_Data_Out` is unchanged.
- **Contention:**
  - Action: hold `P_Req` and `D_Req` high from reset for 4 transactions (each requester re-requests after Done).
  - Check: grant order is P, D, P, D; `Grant` is 00 in every RELEASE cycle.
- **Timeout and error:**
  - Action: `TIMEOUT_CYCLES`=8, MFC never asserted. Check: `P_Done`=1, `P_Error`=1 at E8, and `P_Data_Out` is unchanged.
  - Action: assert `MEM_ERROR` and `MEM_MFC` together at E2 on a read. Check: Error=1 and Data_Out is not updated.
- **Reset mid-ACCESS:**
  - Action: assert Reset at E2 of a debug read, then assert MFC at E3.
  - Check: no `D_Done`; bus at 10; the next tie after reset is granted to the processor.
